// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mixing path.
package audio_pkg;

  localparam int AUDIO_DATA_W = 24;
  localparam int GAIN_UNITY   = 128;

  localparam logic [AUDIO_DATA_W-1:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [AUDIO_DATA_W-1:0] SAT_MIN = 24'h800000;

  typedef enum logic [1:0] {
    FADE_OFF,
    FADE_RAMP_UP,
    FADE_ON,
    FADE_RAMP_DOWN
  } fade_state_e;

endpackage

// File: rtl/fade_gain.sv
// Per-track fade FSM: ramps the gain toward unity or zero, one step per sample strobe.
module fade_gain
  import audio_pkg::*;
#(
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              target_on,
  output logic [GAIN_W-1:0] gain,
  output logic              ramping
);

  localparam int UNITY = 1 << (GAIN_W - 1);

  fade_state_e       r_state;
  logic [GAIN_W-1:0] r_gain;

  int                w_up_i;
  int                w_dn_i;
  logic              w_up_done;
  logic              w_dn_done;
  logic [GAIN_W-1:0] w_gain_up;
  logic [GAIN_W-1:0] w_gain_dn;

  // Steps are computed in int so a step that does not divide unity clamps instead of wrapping.
  always_comb begin
    w_up_i    = int'(r_gain) + RAMP_STEP;
    w_dn_i    = int'(r_gain) - RAMP_STEP;
    w_up_done = (w_up_i >= UNITY);
    w_dn_done = (w_dn_i <= 0);
    w_gain_up = w_up_done ? GAIN_W'(UNITY) : GAIN_W'(w_up_i);
    w_gain_dn = w_dn_done ? '0 : GAIN_W'(w_dn_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FADE_OFF;
      r_gain  <= '0;
    end else if (ena) begin
      case (r_state)
        FADE_OFF: begin
          if (target_on) begin
            r_gain  <= w_gain_up;
            r_state <= w_up_done ? FADE_ON : FADE_RAMP_UP;
          end
        end
        FADE_RAMP_UP, FADE_RAMP_DOWN: begin
          if (target_on) begin
            r_gain  <= w_gain_up;
            r_state <= w_up_done ? FADE_ON : FADE_RAMP_UP;
          end else begin
            r_gain  <= w_gain_dn;
            r_state <= w_dn_done ? FADE_OFF : FADE_RAMP_DOWN;
          end
        end
        FADE_ON: begin
          if (!target_on) begin
            r_gain  <= w_gain_dn;
            r_state <= w_dn_done ? FADE_OFF : FADE_RAMP_DOWN;
          end
        end
        default: begin
          r_gain  <= '0;
          r_state <= FADE_OFF;
        end
      endcase
    end
  end

  assign gain    = r_gain;
  assign ramping = (r_state == FADE_RAMP_UP) || (r_state == FADE_RAMP_DOWN);

endmodule

// File: rtl/fade_mixer.sv
// Two-track stereo mixer: per-track gain ramp, sum, and saturation to DATA_W bits.
module fade_mixer
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUDIO_DATA_W,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              cs1,
  input  logic              cs2,
  input  logic              mute,
  input  logic [DATA_W-1:0] l_in1,
  input  logic [DATA_W-1:0] r_in1,
  input  logic [DATA_W-1:0] l_in2,
  input  logic [DATA_W-1:0] r_in2,
  output logic [DATA_W-1:0] l_data,
  output logic [DATA_W-1:0] r_data,
  output logic              out_valid,
  output logic              clip,
  output logic              busy
);

  localparam int NUM_TRK = 2;
  localparam int SHIFT   = GAIN_W - 1;
  localparam int PROD_W  = DATA_W + GAIN_W + 1;
  localparam int SCL_W   = PROD_W - SHIFT;
  localparam int SUM_W   = SCL_W + 1;

  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;
  localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [NUM_TRK-1:0]             w_target;
  logic [NUM_TRK-1:0]             w_ramping;
  logic [NUM_TRK-1:0][GAIN_W-1:0] w_gain;
  logic [NUM_TRK-1:0][DATA_W-1:0] w_l_in;
  logic [NUM_TRK-1:0][DATA_W-1:0] w_r_in;
  logic [NUM_TRK-1:0][SCL_W-1:0]  w_l_scl;
  logic [NUM_TRK-1:0][SCL_W-1:0]  w_r_scl;
  logic [NUM_TRK-1:0][SCL_W-1:0]  r_l_scl;
  logic [NUM_TRK-1:0][SCL_W-1:0]  r_r_scl;
  logic [2:0]                     r_vld_pipe;

  assign w_target = {cs2 & ~mute, cs1 & ~mute};
  assign w_l_in   = {l_in2, l_in1};
  assign w_r_in   = {r_in2, r_in1};

  // Stage 1 uses the gain registered before this strobe's FSM update.
  for (genvar t = 0; t < NUM_TRK; t++) begin : g_trk
    logic signed [PROD_W-1:0] w_l_prod;
    logic signed [PROD_W-1:0] w_r_prod;

    fade_gain #(
      .GAIN_W   (GAIN_W),
      .RAMP_STEP(RAMP_STEP)
    ) u_gain (
      .clk      (clk),
      .reset    (reset),
      .ena      (ena),
      .target_on(w_target[t]),
      .gain     (w_gain[t]),
      .ramping  (w_ramping[t])
    );

    assign w_l_prod   = PROD_W'($signed(w_l_in[t])) * PROD_W'($signed({1'b0, w_gain[t]}));
    assign w_r_prod   = PROD_W'($signed(w_r_in[t])) * PROD_W'($signed({1'b0, w_gain[t]}));
    assign w_l_scl[t] = SCL_W'(w_l_prod >>> SHIFT);
    assign w_r_scl[t] = SCL_W'(w_r_prod >>> SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l_scl    <= '0;
      r_r_scl    <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], ena};
      if (ena) begin
        r_l_scl <= w_l_scl;
        r_r_scl <= w_r_scl;
      end
    end
  end

  logic signed [SUM_W-1:0] w_l_sum;
  logic signed [SUM_W-1:0] w_r_sum;
  logic                    w_l_hi;
  logic                    w_l_lo;
  logic                    w_r_hi;
  logic                    w_r_lo;
  logic [DATA_W-1:0]       w_l_sat;
  logic [DATA_W-1:0]       w_r_sat;

  assign w_l_sum = SUM_W'($signed(r_l_scl[0])) + SUM_W'($signed(r_l_scl[1]));
  assign w_r_sum = SUM_W'($signed(r_r_scl[0])) + SUM_W'($signed(r_r_scl[1]));
  assign w_l_hi  = (w_l_sum > SUM_MAX);
  assign w_l_lo  = (w_l_sum < SUM_MIN);
  assign w_r_hi  = (w_r_sum > SUM_MAX);
  assign w_r_lo  = (w_r_sum < SUM_MIN);
  assign w_l_sat = w_l_hi ? OUT_MAX : (w_l_lo ? OUT_MIN : w_l_sum[DATA_W-1:0]);
  assign w_r_sat = w_r_hi ? OUT_MAX : (w_r_lo ? OUT_MIN : w_r_sum[DATA_W-1:0]);

  logic [DATA_W-1:0] r_l_s2;
  logic [DATA_W-1:0] r_r_s2;
  logic              r_clip_s2;
  logic [DATA_W-1:0] r_l_data;
  logic [DATA_W-1:0] r_r_data;
  logic              r_clip;

  // Outputs only move on the update pulse so the serializer always sees a settled sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l_s2    <= '0;
      r_r_s2    <= '0;
      r_clip_s2 <= 1'b0;
      r_l_data  <= '0;
      r_r_data  <= '0;
      r_clip    <= 1'b0;
    end else begin
      if (r_vld_pipe[0]) begin
        r_l_s2    <= w_l_sat;
        r_r_s2    <= w_r_sat;
        r_clip_s2 <= w_l_hi | w_l_lo | w_r_hi | w_r_lo;
      end
      if (r_vld_pipe[1]) begin
        r_l_data <= r_l_s2;
        r_r_data <= r_r_s2;
        r_clip   <= r_clip_s2;
      end
    end
  end

  assign l_data    = r_l_data;
  assign r_data    = r_r_data;
  assign clip      = r_clip;
  assign out_valid = r_vld_pipe[2];
  assign busy      = |w_ramping;

endmodule

// File: tb/tb_fade_mixer.sv
// Directed bench for fade_mixer: reset, ramps, reversal, mute, saturation and strobe timing.
module tb_fade_mixer;

  logic        clk = 1'b0;
  logic        reset, ena, cs1, cs2, mute;
  logic [23:0] l_in1, r_in1, l_in2, r_in2;
  logic [23:0] l_data, r_data;
  logic        out_valid, clip, busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fade_mixer dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .cs1      (cs1),
    .cs2      (cs2),
    .mute     (mute),
    .l_in1    (l_in1),
    .r_in1    (r_in1),
    .l_in2    (l_in2),
    .r_in2    (r_in2),
    .l_data   (l_data),
    .r_data   (r_data),
    .out_valid(out_valid),
    .clip     (clip),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the result lands.
  task automatic strobe();
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    chk("valid_clk1", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("valid_clk2", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("valid_clk3", {31'd0, out_valid}, 1);
  endtask

  initial begin
    int g;
    reset = 1'b1; ena = 1'b0; cs1 = 1'b1; cs2 = 1'b1; mute = 1'b0;
    l_in1 = 24'h123456; r_in1 = 24'h654321; l_in2 = 24'hABCDEF; r_in2 = 24'h0F0F0F;
    repeat (2) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("rst_l", $signed(l_data), 0);
    chk("rst_r", $signed(r_data), 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_clip", {31'd0, clip}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    reset = 1'b0;
    @(negedge clk);
    strobe();
    chk("first_l", $signed(l_data), 0);
    chk("first_r", $signed(r_data), 0);
    chk("first_clip", {31'd0, clip}, 0);
    chk("first_busy", {31'd0, busy}, 1);

    // reset while ramping drops the gain straight back to zero
    reset = 1'b1;
    #1;
    chk("midramp_busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // track 1 ramp up, track 2 off
    cs2 = 1'b0; l_in1 = 24'h400000; r_in1 = 24'hC00000;
    for (int k = 0; k <= 130; k++) begin
      if (k == 60) begin
        cs1 = 1'b0; mute = 1'b1; l_in1 = 24'h7FFFFF;
        @(negedge clk);
        cs1 = 1'b1; mute = 1'b0; l_in1 = 24'h400000;
      end
      strobe();
      g = (k < 128) ? k : 128;
      chk("ramp_l", $signed(l_data), 32768 * g);
      chk("ramp_r", $signed(r_data), -32768 * g);
      if (k <= 126) chk("ramp_busy", {31'd0, busy}, 1);
      if (k >= 128) chk("ramp_idle", {31'd0, busy}, 0);
    end

    // both tracks at the rails
    l_in1 = 24'h7FFFFF; l_in2 = 24'h7FFFFF; r_in1 = 24'h800000; r_in2 = 24'h800000; cs2 = 1'b1;
    repeat (130) strobe();
    chk("sat_pos_l", $signed(l_data), 8388607);
    chk("sat_neg_r", $signed(r_data), -8388608);
    chk("sat_clip", {31'd0, clip}, 1);
    chk("sat_busy", {31'd0, busy}, 0);

    l_in2 = 24'h000000; r_in2 = 24'h000000;
    strobe();
    chk("lim_l", $signed(l_data), 8388607);
    chk("lim_r", $signed(r_data), -8388608);
    chk("lim_clip", {31'd0, clip}, 0);

    l_in1 = 24'h400000; l_in2 = 24'h3FFFFF; r_in1 = 24'hC00000; r_in2 = 24'hBFFFFF;
    strobe();
    chk("one_l", $signed(l_data), 8388607);
    chk("one_r", $signed(r_data), -8388608);
    chk("one_clip", {31'd0, clip}, 1);

    // mute: both tracks fade together; -1 scaled by any nonzero gain floors to -1
    l_in1 = 24'hFFFFFF; l_in2 = 24'h000000; r_in1 = 24'd1000; r_in2 = 24'd2000; mute = 1'b1;
    for (int j = 0; j <= 130; j++) begin
      strobe();
      g = (j < 128) ? (128 - j) : 0;
      chk("mute_l", $signed(l_data), (g > 0) ? -1 : 0);
      chk("mute_r", $signed(r_data), (1000 * g) / 128 + (2000 * g) / 128);
      if (j <= 126) chk("mute_busy", {31'd0, busy}, 1);
      if (j >= 128) chk("mute_idle", {31'd0, busy}, 0);
    end

    l_in1 = 24'h7FFFFF; l_in2 = 24'h7FFFFF; r_in1 = 24'h800000; r_in2 = 24'h800000;
    strobe();
    chk("off_l", $signed(l_data), 0);
    chk("off_r", $signed(r_data), 0);
    chk("off_clip", {31'd0, clip}, 0);

    // reversal after 50 strobes of ramp-up
    mute = 1'b0; cs2 = 1'b0; cs1 = 1'b1;
    l_in1 = 24'h400000; r_in1 = 24'h000000; l_in2 = 24'h7FFFFF; r_in2 = 24'h7FFFFF;
    for (int j = 0; j <= 102; j++) begin
      if (j == 50) cs1 = 1'b0;
      strobe();
      g = (j < 50) ? j : ((j <= 100) ? (100 - j) : 0);
      chk("rev_l", $signed(l_data), 32768 * g);
      chk("rev_r", $signed(r_data), 0);
      if (j == 98) chk("rev_busy", {31'd0, busy}, 1);
      if (j == 99) chk("rev_off", {31'd0, busy}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
